// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    FILL = 2'd2
  } state_t;

  localparam logic [1:0] GNT_C0 = 2'd0;
  localparam logic [1:0] GNT_C1 = 2'd1;
  localparam logic [1:0] GNT_WR = 2'd2;

  localparam int DEF_BURST_LEN = 8;

endpackage

// File: rtl/sdram_grant_select.sv
// Combinational winner choice: writes first, a starved cache overrides, round-robin between caches.
module sdram_grant_select
  import sdram_arb_pkg::*;
#(
  parameter int WR_LIMIT = 4,
  parameter int STREAK_W = $clog2(WR_LIMIT + 1)
) (
  input  logic                wr_req,
  input  logic                c0_req,
  input  logic                c1_req,
  input  logic                rr_ptr,
  input  logic [STREAK_W-1:0] wr_streak,
  output logic [1:0]          gnt_id,
  output logic                gnt_valid
);

  logic cache_pend;
  logic wr_blocked;
  logic [1:0] cache_pick;

  // NOTE: purely combinational; every output gets a default before any branch so no latch is inferred.
  always_comb begin
    gnt_id     = GNT_WR;
    gnt_valid  = 1'b0;
    cache_pend = c0_req | c1_req;
    wr_blocked = (wr_streak == STREAK_W'(WR_LIMIT)) && cache_pend;
    // rr_ptr = 0 favours cache 0; the other cache wins only if the favoured one is quiet.
    if (rr_ptr) cache_pick = c1_req ? GNT_C1 : GNT_C0;
    else        cache_pick = c0_req ? GNT_C0 : GNT_C1;

    if (wr_req && !wr_blocked) begin
      gnt_id    = GNT_WR;
      gnt_valid = 1'b1;
    end else if (cache_pend) begin
      gnt_id    = cache_pick;
      gnt_valid = 1'b1;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between two cache fill requesters and a CPU write port.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W    = 26,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int WR_LIMIT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_req,
  input  logic [ADDR_W-1:0] c0_addr,
  output logic              c0_fill,
  input  logic              c1_req,
  input  logic [ADDR_W-1:0] c1_addr,
  output logic              c1_fill,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              wr_uds_n,
  input  logic              wr_lds_n,
  output logic              wr_ack,
  output logic              sdram_req,
  output logic              sdram_rw,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [15:0]       sdram_wdata,
  output logic              sdram_uds_n,
  output logic              sdram_lds_n,
  input  logic              sdram_ack,
  input  logic              sdram_fill,
  output logic              fill_err
);

  localparam int STREAK_W = $clog2(WR_LIMIT + 1);
  localparam int BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_t              state, state_nxt;
  logic [1:0]          sel_id;
  logic                sel_valid;
  logic [1:0]          gnt_q;
  logic                rr_ptr;
  logic [STREAK_W-1:0] wr_streak;
  logic [BEAT_W-1:0]   beat_cnt;
  logic                grant;
  logic                cmd_done;

  sdram_grant_select #(
    .WR_LIMIT (WR_LIMIT),
    .STREAK_W (STREAK_W)
  ) u_grant_select (
    .wr_req    (wr_req),
    .c0_req    (c0_req),
    .c1_req    (c1_req),
    .rr_ptr    (rr_ptr),
    .wr_streak (wr_streak),
    .gnt_id    (sel_id),
    .gnt_valid (sel_valid)
  );

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    cmd_done  = 1'b0;
    case (state)
      IDLE: if (sel_valid) begin
        grant     = 1'b1;
        state_nxt = CMD;
      end
      CMD: if (sdram_ack) begin
        cmd_done  = 1'b1;
        state_nxt = (gnt_q == GNT_WR) ? IDLE : FILL;
      end
      FILL: if (sdram_fill && (beat_cnt == LAST_BEAT)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Requester req levels are ignored in FILL; the grant is held until the last beat.
  assign c0_fill = sdram_fill && (state == FILL) && (gnt_q == GNT_C0);
  assign c1_fill = sdram_fill && (state == FILL) && (gnt_q == GNT_C1);

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      gnt_q       <= GNT_C0;
      rr_ptr      <= 1'b0;
      wr_streak   <= '0;
      beat_cnt    <= '0;
      wr_ack      <= 1'b0;
      sdram_req   <= 1'b0;
      sdram_rw    <= 1'b1;
      sdram_addr  <= '0;
      sdram_wdata <= '0;
      sdram_uds_n <= 1'b1;
      sdram_lds_n <= 1'b1;
      fill_err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      wr_ack <= 1'b0;

      if (grant) begin
        gnt_q     <= sel_id;
        sdram_req <= 1'b1;
        if (sel_id == GNT_WR) begin
          sdram_rw    <= 1'b0;
          sdram_addr  <= wr_addr;
          sdram_wdata <= wr_data;
          sdram_uds_n <= wr_uds_n;
          sdram_lds_n <= wr_lds_n;
          if (wr_streak != STREAK_W'(WR_LIMIT)) wr_streak <= wr_streak + 1'b1;
        end else begin
          sdram_rw    <= 1'b1;
          sdram_addr  <= (sel_id == GNT_C0) ? c0_addr : c1_addr;
          sdram_uds_n <= 1'b0;
          sdram_lds_n <= 1'b0;
          wr_streak   <= '0;
          rr_ptr      <= (sel_id == GNT_C0);
        end
      end

      if (cmd_done) begin
        sdram_req <= 1'b0;
        if (gnt_q == GNT_WR) wr_ack <= 1'b1;
        else                 beat_cnt <= '0;
      end

      if (state == FILL && sdram_fill) beat_cnt <= beat_cnt + 1'b1;
      if (state != FILL && sdram_fill) fill_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench: stimulus queues expected SDRAM commands, a monitor pops them on each new sdram_req.
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  localparam int ADDR_W    = 26;
  localparam int BURST_LEN = 8;
  localparam int WR_LIMIT  = 4;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic              uds_n;
    logic              lds_n;
  } cmd_t;

  logic clk = 1'b0;
  logic reset;
  logic c0_req, c1_req, wr_req;
  logic [ADDR_W-1:0] c0_addr, c1_addr, wr_addr;
  logic [15:0] wr_data;
  logic wr_uds_n, wr_lds_n;
  logic c0_fill, c1_fill, wr_ack, fill_err;
  logic sdram_req, sdram_rw, sdram_uds_n, sdram_lds_n;
  logic [ADDR_W-1:0] sdram_addr;
  logic [15:0] sdram_wdata;
  logic sdram_ack, sdram_fill;
  logic resp_ack, resp_fill, man_ack, man_fill;

  assign sdram_ack  = resp_ack | man_ack;
  assign sdram_fill = resp_fill | man_fill;

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .WR_LIMIT(WR_LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c0_addr(c0_addr), .c0_fill(c0_fill),
    .c1_req(c1_req), .c1_addr(c1_addr), .c1_fill(c1_fill),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_uds_n(wr_uds_n), .wr_lds_n(wr_lds_n), .wr_ack(wr_ack),
    .sdram_req(sdram_req), .sdram_rw(sdram_rw), .sdram_addr(sdram_addr),
    .sdram_wdata(sdram_wdata), .sdram_uds_n(sdram_uds_n), .sdram_lds_n(sdram_lds_n),
    .sdram_ack(sdram_ack), .sdram_fill(sdram_fill), .fill_err(fill_err)
  );

  int   total = 0;
  int   bad = 0;
  int   cmd_seen = 0;
  int   cnt0 = 0;
  int   cnt1 = 0;
  int   wr_ack_cnt = 0;
  cmd_t exp_q[$];
  bit   auto_resp = 1'b1;
  int   ack_delay = 0;
  int   gap_pat[BURST_LEN];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  function automatic cmd_t rd_cmd(input logic [ADDR_W-1:0] a);
    rd_cmd = '{rw: 1'b1, addr: a, wdata: 16'h0, uds_n: 1'b0, lds_n: 1'b0};
  endfunction

  function automatic cmd_t wr_cmd(input logic [ADDR_W-1:0] a, input logic [15:0] d,
                                  input logic u, input logic l);
    wr_cmd = '{rw: 1'b0, addr: a, wdata: d, uds_n: u, lds_n: l};
  endfunction

  // Monitor: scoreboard pop on each new command, plus fill and wr_ack counters.
  initial begin
    logic prev_req;
    cmd_t e;
    logic [63:0] act, want;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (sdram_req && !prev_req) begin
        cmd_seen++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL cmd_unexpected: got rw=%0d addr=0x%0h, expected no command", sdram_rw, sdram_addr);
        end else begin
          e = exp_q.pop_front();
          act  = {19'd0, sdram_rw, sdram_addr, sdram_uds_n, sdram_lds_n, e.rw ? 16'h0 : sdram_wdata};
          want = {19'd0, e.rw, e.addr, e.uds_n, e.lds_n, e.rw ? 16'h0 : e.wdata};
          check($sformatf("cmd%0d", cmd_seen), act, want);
        end
      end
      prev_req = sdram_req;
      if (c0_fill) cnt0++;
      if (c1_fill) cnt1++;
      if (wr_ack) wr_ack_cnt++;
    end
  end

  // SDRAM controller model: ack after ack_delay cycles, then BURST_LEN beats with gap_pat idle cycles.
  initial begin
    bit is_read;
    resp_ack  = 1'b0;
    resp_fill = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (auto_resp && reset && sdram_req) begin
        repeat (ack_delay) begin @(posedge clk); #1; end
        is_read  = sdram_rw;
        resp_ack = 1'b1;
        @(posedge clk); #1;
        resp_ack = 1'b0;
        if (is_read) begin
          for (int b = 0; b < BURST_LEN; b++) begin
            repeat (gap_pat[b]) begin @(posedge clk); #1; end
            resp_fill = 1'b1;
            @(posedge clk); #1;
            resp_fill = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic wait_cmds(input int target, input string name);
    for (int n = 0; n < 400 && cmd_seen < target; n++) begin @(negedge clk); #1; end
    check(name, cmd_seen, target);
  endtask

  task automatic wait_fill(input int cache, input int target, input string name);
    for (int n = 0; n < 400 && ((cache == 0) ? cnt0 : cnt1) < target; n++) begin
      @(negedge clk); #1;
    end
    check(name, (cache == 0) ? cnt0 : cnt1, target);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"}, sdram_req, 1'b0);
    check({tag, "_rw"}, sdram_rw, 1'b1);
    check({tag, "_strobes"}, {sdram_uds_n, sdram_lds_n}, 2'b11);
    check({tag, "_addr_wdata"}, {sdram_addr, sdram_wdata}, '0);
    check({tag, "_pulses"}, {wr_ack, c0_fill, c1_fill}, 3'b000);
    check({tag, "_fill_err"}, fill_err, 1'b0);
    check({tag, "_state"}, dut.state, IDLE);
    check({tag, "_internal"}, {dut.rr_ptr, dut.wr_streak, dut.beat_cnt}, '0);
  endtask

  initial begin
    int base0, base1, bc, bw;
    bit early;
    reset = 1'b0;
    c0_req = 1'b0; c1_req = 1'b0; wr_req = 1'b0;
    c0_addr = '0; c1_addr = '0; wr_addr = '0; wr_data = '0;
    wr_uds_n = 1'b1; wr_lds_n = 1'b1;
    man_ack = 1'b0; man_fill = 1'b0;
    for (int b = 0; b < BURST_LEN; b++) gap_pat[b] = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1;
    reset = 1'b1;

    // Single read from cache 0 with a slow ack.
    base0 = cnt0; base1 = cnt1;
    ack_delay = 2;
    exp_q.push_back(rd_cmd(26'h0123450));
    @(posedge clk); #1;
    c0_req = 1'b1; c0_addr = 26'h0123450;
    @(negedge clk);
    check("t1_req_before_edge", sdram_req, 1'b0);
    @(negedge clk);
    check("t1_req_latency", sdram_req, 1'b1);
    c0_req = 1'b0;
    repeat (2) @(negedge clk);
    check("t1_req_held", {sdram_req, sdram_rw, sdram_addr}, {1'b1, 1'b1, 26'h0123450});
    ack_delay = 0;
    wait_fill(0, base0 + 8, "t1_c0_beats");
    @(negedge clk);
    check("t1_idle_after_burst", dut.state, IDLE);
    check("t1_c1_quiet", cnt1, base1);

    // Gapped fill to cache 1; must not return to IDLE early.
    base1 = cnt1; bc = cmd_seen;
    gap_pat = '{0, 1, 2, 3, 0, 3, 1, 2};
    exp_q.push_back(rd_cmd(26'h0ABCDE0));
    @(posedge clk); #1;
    c1_req = 1'b1; c1_addr = 26'h0ABCDE0;
    wait_cmds(bc + 1, "t4_grant");
    c1_req = 1'b0;
    early = 1'b0;
    for (int n = 0; n < 400 && cnt1 < base1 + 8; n++) begin
      @(negedge clk); #1;
      if (cnt1 > base1 && cnt1 < base1 + 8 && dut.state != FILL) early = 1'b1;
    end
    check("t4_c1_beats", cnt1, base1 + 8);
    check("t4_no_early_idle", early, 1'b0);
    @(negedge clk);
    check("t4_idle_after_burst", dut.state, IDLE);
    for (int b = 0; b < BURST_LEN; b++) gap_pat[b] = 0;

    // All three requesting: W,W,W,W,C0,W,W,W,W,C1.
    base0 = cnt0; base1 = cnt1; bc = cmd_seen; bw = wr_ack_cnt;
    for (int k = 0; k < 4; k++) exp_q.push_back(wr_cmd(26'h0200000, 16'hBEEF, 1'b1, 1'b0));
    exp_q.push_back(rd_cmd(26'h0000100));
    for (int k = 0; k < 4; k++) exp_q.push_back(wr_cmd(26'h0200000, 16'hBEEF, 1'b1, 1'b0));
    exp_q.push_back(rd_cmd(26'h0000200));
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = 26'h0200000; wr_data = 16'hBEEF; wr_uds_n = 1'b1; wr_lds_n = 1'b0;
    c0_req = 1'b1; c0_addr = 26'h0000100;
    c1_req = 1'b1; c1_addr = 26'h0000200;
    wait_cmds(bc + 10, "t2_ten_grants");
    wr_req = 1'b0; c0_req = 1'b0; c1_req = 1'b0;
    wait_fill(1, base1 + 8, "t2_c1_beats");
    repeat (3) @(negedge clk);
    check("t2_queue_empty", exp_q.size(), 0);
    check("t2_wr_acks", wr_ack_cnt - bw, 8);
    check("t2_c0_beats", cnt0 - base0, 8);

    // Round-robin between caches; cache 0 drops req after its first beat.
    base0 = cnt0; base1 = cnt1; bc = cmd_seen;
    exp_q.push_back(rd_cmd(26'h0000A00));
    exp_q.push_back(rd_cmd(26'h0000B00));
    exp_q.push_back(rd_cmd(26'h0000A00));
    @(posedge clk); #1;
    c0_req = 1'b1; c0_addr = 26'h0000A00;
    c1_req = 1'b1; c1_addr = 26'h0000B00;
    wait_fill(0, base0 + 1, "t3_first_beat");
    c0_req = 1'b0;
    wait_cmds(bc + 2, "t3_second_grant");
    check("t3_c0_full_burst", cnt0 - base0, 8);
    c0_req = 1'b1;
    wait_cmds(bc + 3, "t3_third_grant");
    c0_req = 1'b0; c1_req = 1'b0;
    wait_fill(0, base0 + 16, "t3_c0_beats");
    repeat (3) @(negedge clk);
    check("t3_c1_beats", cnt1 - base1, 8);
    check("t3_queue_empty", exp_q.size(), 0);

    // Stray fill in IDLE, then reset in the middle of a burst.
    auto_resp = 1'b0;
    @(posedge clk); #1;
    man_fill = 1'b1;
    @(negedge clk);
    check("t5_stray_not_fwd", {c0_fill, c1_fill}, 2'b00);
    @(posedge clk); #1;
    man_fill = 1'b0;
    @(negedge clk);
    check("t5_stray_err_state", {fill_err, dut.state}, {1'b1, IDLE});
    repeat (3) @(negedge clk);
    check("t5_err_sticky", fill_err, 1'b1);

    exp_q.push_back(rd_cmd(26'h1111110));
    @(posedge clk); #1;
    c0_req = 1'b1; c0_addr = 26'h1111110;
    @(posedge clk); #1;
    c0_req = 1'b0;
    man_ack = 1'b1;
    @(posedge clk); #1;
    man_ack = 1'b0;
    for (int b = 0; b < 4; b++) begin
      man_fill = 1'b1;
      if (b == 3) reset = 1'b0;
      @(negedge clk);
      if (b == 1) check("t5_beat_fwd_err_kept", {c0_fill, c1_fill, fill_err}, 3'b101);
      @(posedge clk); #1;
      man_fill = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("t5_midrst");

    base1 = cnt1; bc = cmd_seen;
    auto_resp = 1'b1;
    exp_q.push_back(rd_cmd(26'h0F0F0F0));
    @(posedge clk); #1;
    c1_req = 1'b1; c1_addr = 26'h0F0F0F0;
    wait_cmds(bc + 1, "t5_new_grant");
    c1_req = 1'b0;
    wait_fill(1, base1 + 8, "t5_c1_beats");
    @(negedge clk);
    check("t5_idle_queue", {dut.state, 8'(exp_q.size())}, {IDLE, 8'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single SDRAM controller port between two two-way cache fill requesters (instruction and data cache) and one write-through CPU write port. It sits between the caches/CPU write path and the SDRAM controller. It grants one requester at a time and drives the address, direction and byte strobes. It steers fill beats only to the granted cache, and holds the grant for the whole burst even after the cache drops its request.

## Interface
Parameters:
- ADDR_W, 26: byte address width passed to SDRAM (bit 0 unused).
- BURST_LEN, 8: fill beats per cache-line read.
- WR_LIMIT, 4: max consecutive write grants while a cache request is pending.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low.
- c0_req  in  1  cache 0 fill request (level).
- c0_addr  in  ADDR_W  cache 0 miss address.
- c0_fill  out  1  beat-valid strobe to cache 0.
- c1_req, c1_addr, c1_fill: same as cache 0, for cache 1.
- wr_req  in  1  CPU write request (level).
- wr_addr  in  ADDR_W  write address.
- wr_data  in  16  write data.
- wr_uds_n, wr_lds_n  in  1 each  byte strobes, active low.
- wr_ack  out  1  one-cycle pulse when the SDRAM controller accepts the write.
- sdram_req  out  1  command request.
- sdram_rw  out  1  1 = read burst, 0 = write.
- sdram_addr  out  ADDR_W  latched command address.
- sdram_wdata  out  16  latched write data.
- sdram_uds_n, sdram_lds_n  out  1 each  latched byte strobes; both 0 for reads.
- sdram_ack  in  1  command accepted (one-cycle pulse).
- sdram_fill  in  1  read beat valid; BURST_LEN pulses per read, may be non-contiguous.
- fill_err  out  1  sticky flag: sdram_fill seen with no read in flight.

Read data is not routed through this block; caches take data_from_sdram directly.

## Operation
- States: IDLE, CMD, FILL.
- **IDLE:** sample requests; pick a winner; latch its address, rw, wdata and strobes into the sdram_* registers; assert sdram_req; go to CMD.
- **Priority:** wr_req beats caches unless wr_streak == WR_LIMIT and (c0_req | c1_req).
  - Between caches: round-robin pointer. The pointer flips to the other cache after each cache grant. After reset it favours cache 0.
  - wr_streak increments per write grant and clears on any cache grant. It saturates at WR_LIMIT.
- **CMD:** hold sdram_req and all latched fields until sdram_ack.
  - On ack, sdram_req drops. A write pulses wr_ack and returns to IDLE. A read clears beat_cnt and goes to FILL.
- **FILL:** each sdram_fill pulse is copied combinationally to cX_fill of the granted cache only, and beat_cnt increments.
  - When the beat with beat_cnt == BURST_LEN-1 arrives, go to IDLE.
  - Requester req level is ignored in FILL, because the cache drops req on its first beat.
- A request withdrawn before grant is simply not seen; requests are sampled only in IDLE.
- sdram_fill outside FILL sets fill_err, is not forwarded, and does not change state.
- beat_cnt width is clog2(BURST_LEN); it is never compared beyond BURST_LEN-1.

## Timing
- **Reset values:** state IDLE, every output 0 except sdram_rw=1 and sdram_uds_n=sdram_lds_n=1. Also rr pointer=0, wr_streak=0, beat_cnt=0, fill_err=0.
- **Reset mid-operation:** reset during CMD or FILL aborts immediately. The next cycle is IDLE with reset values; the SDRAM controller shares the reset.
- **Grant latency:** request high in IDLE at edge N gives sdram_req=1 after edge N.
- **Write completion:** sdram_ack at edge M gives wr_ack=1 and sdram_req=0 for the cycle after M, and state IDLE. The earliest next grant is one cycle later.
- **Fill strobes:** cX_fill has zero latency from sdram_fill (combinational AND with grant and FILL state).
- **Return to IDLE:** FILL returns to IDLE on the edge that samples the last beat.
- **Back-to-back throughput:** minimum 2 cycles per write (IDLE, CMD with immediate ack).

## Structure
- **Shared package `sdram_arb_pkg`:**
  - state enum (IDLE/CMD/FILL);
  - grant ID constants GNT_C0, GNT_C1, GNT_WR (2-bit);
  - default BURST_LEN.
- **Sub-module `sdram_grant_select`:** combinational winner choice from {wr_req, c0_req, c1_req, rr_ptr, wr_streak}, returning a grant ID and a valid bit.
- **Top level:** registers, FSM and fill steering.

## Test plan
- **Single read:** c0_req=1, addr 0x0123450 → sdram_req next cycle with rw=1 and addr 0x0123450. After ack, 8 sdram_fill pulses appear on c0_fill only and c1_fill stays 0; state is IDLE after beat 8.
- **Simultaneous requests:** wr_req, c0_req and c1_req all set, with ack every CMD → grant order W,W,W,W,C0,W,W,W,W,C1. wr_ack pulses once per write, and wdata/strobes match inputs (e.g. 0xBEEF, lds_n=0, uds_n=1).
- **Cache round-robin:** c0_req and c1_req held high → grants alternate C0,C1,C0; c0 is drops req after beat 1 but still receives all 8 c0_fill beats.
- **Gapped fill:** sdram_fill with 0–3 idle cycles between beats → exactly 8 beats forwarded, and no early return to IDLE.
- **Stray fill and reset mid-burst:**
  - sdram_fill in IDLE → fill_err=1 and stays set.
  - reset low at beat 4 → next cycle all outputs at reset values, fill_err cleared.
  - a new c1_req is then granted normally.
